fwd_select_unit: RTL and testbench

- Generates the 2-bit operand select codes consumed by the EX-stage 3-to-1 operand multiplexers of the 5-stage pipelined CPU.
- Tracks destination-register and control history of the instructions in EX, MEM and WB in internal pipeline records.
- Produces forwarding selects for the instruction in EX, and a load-use stall request for the instruction in ID.
- Select encoding matches the operand mux: 0 = register-file operand, 1 = EX/MEM ALU result, 2 = MEM/WB write-back data; 3 is never driven.

---
 rtl/fwd_select_unit.sv | 101 ++++++++++
 tb/tb_fwd_select_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_select_unit.sv
// Operand-forwarding select and load-use stall generator for the EX stage of a
// 5-stage pipeline. It keeps its own EX/MEM/WB copies of the destination and control history.
module fwd_select_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic [REG_ADDR_W-1:0] id_wr_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  flush_i,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic                  stall_o
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  uses_rt;
        logic [REG_ADDR_W-1:0] wr;
        logic                  regwrite;
        logic                  memread;
    } ex_rec_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wr;
        logic                  regwrite;
        logic                  memread;
    } mem_rec_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wr;
        logic                  regwrite;
    } wb_rec_t;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    ex_rec_t  r_ex;
    mem_rec_t r_mem;
    wb_rec_t  r_wb;

    ex_rec_t  w_id;
    logic     w_take;
    logic     w_stall;
    logic     w_rs_hit;
    logic     w_rt_hit;

    // The MEM-stage match is checked first: it holds the newer value of the register.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                           input mem_rec_t m, input wb_rec_t w);
        logic [1:0] s;
        s = SEL_RF;
        if (m.regwrite && (m.wr != '0) && (m.wr == src))
            s = SEL_MEM;
        else if (w.regwrite && (w.wr != '0) && (w.wr == src))
            s = SEL_WB;
        return s;
    endfunction

    always_comb begin
        w_id          = '0;
        w_id.rs       = id_rs_i;
        w_id.rt       = id_rt_i;
        w_id.uses_rt  = id_uses_rt_i;
        w_id.wr       = id_wr_i;
        w_id.regwrite = id_regwrite_i;
        w_id.memread  = id_memread_i;
    end

    assign w_rs_hit = (r_ex.wr == id_rs_i);
    assign w_rt_hit = id_uses_rt_i && (r_ex.wr == id_rt_i);
    assign w_stall  = r_ex.memread && r_ex.regwrite && (r_ex.wr != '0) && (w_rs_hit || w_rt_hit);
    assign w_take   = !w_stall && !flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb.wr        <= r_mem.wr;
            r_wb.regwrite  <= r_mem.regwrite;
            r_mem.wr       <= r_ex.wr;
            r_mem.regwrite <= r_ex.regwrite;
            r_mem.memread  <= r_ex.memread;
            // A stalled or flushed ID instruction turns into an all-zero bubble in EX.
            r_ex           <= w_take ? w_id : '0;
        end
    end

    assign fwd_a_o = fwd_sel(r_ex.rs, r_mem, r_wb);
    assign fwd_b_o = r_ex.uses_rt ? fwd_sel(r_ex.rt, r_mem, r_wb) : SEL_RF;
    assign stall_o = w_stall;

endmodule

// File: tb/tb_fwd_select_unit.sv
// Directed bench for fwd_select_unit: per-cycle expectations go into a scoreboard
// queue when the ID inputs are driven and are checked against the DUT outputs.
module tb_fwd_select_unit;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] id_rs_i = '0, id_rt_i = '0, id_wr_i = '0;
    logic       id_uses_rt_i = 1'b0, id_regwrite_i = 1'b0, id_memread_i = 1'b0, flush_i = 1'b0;
    logic [1:0] fwd_a_o, fwd_b_o;
    logic       stall_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        logic [1:0] a;
        logic [1:0] b;
        logic       s;
    } exp_t;
    exp_t exp_q[$];

    fwd_select_unit #(.REG_ADDR_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
        .id_wr_i(id_wr_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .flush_i(flush_i),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic push(input string tag, input logic [1:0] a, input logic [1:0] b, input logic s);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.s = s;
        exp_q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        tests++;
        assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL scoreboard_empty observed=0 entries expected>=1");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests++;
            assert (fwd_a_o === e.a) else begin
                fails++;
                $error("FAIL %s fwd_a observed=%0d expected=%0d", e.tag, fwd_a_o, e.a);
            end
            tests++;
            assert (fwd_b_o === e.b) else begin
                fails++;
                $error("FAIL %s fwd_b observed=%0d expected=%0d", e.tag, fwd_b_o, e.b);
            end
            tests++;
            assert (stall_o === e.s) else begin
                fails++;
                $error("FAIL %s stall observed=%0d expected=%0d", e.tag, stall_o, e.s);
            end
            tests++;
            assert (!(dut.r_mem.memread && (fwd_a_o == 2'd1 || fwd_b_o == 2'd1))) else begin
                fails++;
                $error("FAIL %s no_mem_fwd_of_load observed a=%0d b=%0d expected no 1", e.tag, fwd_a_o, fwd_b_o);
            end
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic [4:0] wr, input logic rw, input logic mr, input logic fl);
        id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = urt;
        id_wr_i = wr; id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
    endtask

    // One pipeline cycle: drive ID, record what this cycle must show, check mid-cycle, advance.
    task automatic cyc(input string tag, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] wr, input logic rw, input logic mr, input logic fl,
                       input logic [1:0] ea, input logic [1:0] eb, input logic es);
        drive(rs, rt, urt, wr, rw, mr, fl);
        push(tag, ea, eb, es);
        @(negedge clk_i);
        check();
        @(posedge clk_i);
        #1;
    endtask

    task automatic nop(input string tag, input logic [1:0] ea, input logic [1:0] eb);
        cyc(tag, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ea, eb, 1'b0);
    endtask

    initial begin
        push("reset_held", 2'd0, 2'd0, 1'b0);
        @(negedge clk_i);
        check();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // add $3 ; sub $5,$3,$4
        cyc("add3",        5'd1,  5'd2,  1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("sub_in_id",   5'd3,  5'd4,  1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        nop("sub_in_ex",   2'd1, 2'd0);
        nop("drain1",      2'd0, 2'd0);
        nop("drain2",      2'd0, 2'd0);

        // distance 2: add $3 ; X ; use rs=16 rt=3
        cyc("d2_add3",     5'd10, 5'd11, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("d2_x1",       5'd12, 5'd13, 1'b1, 5'd20, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("d2_use",      5'd16, 5'd3,  1'b1, 5'd22, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        nop("d2_use_ex",   2'd0, 2'd2);
        nop("drain3",      2'd0, 2'd0);
        nop("drain4",      2'd0, 2'd0);

        // distance 3: add $3 ; X ; X ; use $3,$3
        cyc("d3_add3",     5'd10, 5'd11, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("d3_x1",       5'd12, 5'd13, 1'b1, 5'd20, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("d3_x2",       5'd14, 5'd15, 1'b1, 5'd21, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("d3_use",      5'd3,  5'd3,  1'b1, 5'd22, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        nop("d3_use_ex",   2'd0, 2'd0);
        nop("drain5",      2'd0, 2'd0);
        nop("drain6",      2'd0, 2'd0);

        // add $3 ; add $3 ; use rs=3 rt=17 -> MEM wins over WB
        cyc("mw_add3a",    5'd10, 5'd11, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("mw_add3b",    5'd17, 5'd18, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("mw_use",      5'd3,  5'd17, 1'b1, 5'd22, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        nop("mw_use_ex",   2'd1, 2'd0);
        nop("drain7",      2'd0, 2'd0);
        nop("drain8",      2'd0, 2'd0);

        // lw $2 ; add $6,$2,$2 -> one stall, then WB forwarding on both operands
        cyc("lu_lw2",      5'd9,  5'd2,  1'b0, 5'd2,  1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("lu_stall",    5'd2,  5'd2,  1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        cyc("lu_held",     5'd2,  5'd2,  1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        nop("lu_add_ex",   2'd2, 2'd2);
        nop("drain9",      2'd0, 2'd0);
        nop("drain10",     2'd0, 2'd0);

        // lw $2 ; addi $7,$8 with rt=2 not read -> no stall
        cyc("ns_lw2",      5'd9,  5'd2,  1'b0, 5'd2,  1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("ns_addi",     5'd8,  5'd2,  1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        nop("ns_addi_ex",  2'd0, 2'd0);
        nop("drain11",     2'd0, 2'd0);
        nop("drain12",     2'd0, 2'd0);

        // writes to $0: load and ALU op never stall or forward
        cyc("z_lw0",       5'd9,  5'd0,  1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("z_use_lw",    5'd0,  5'd0,  1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("z_add0",      5'd10, 5'd11, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("z_use_add",   5'd0,  5'd0,  1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        nop("z_use_ex",    2'd0, 2'd0);
        nop("drain13",     2'd0, 2'd0);
        nop("drain14",     2'd0, 2'd0);

        // load-use pair flushed on its stall cycle
        cyc("fl_lw2",      5'd9,  5'd2,  1'b0, 5'd2,  1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("fl_stall",    5'd2,  5'd2,  1'b1, 5'd6,  1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1);
        nop("fl_bubble",   2'd0, 2'd0);
        nop("fl_after",    2'd0, 2'd0);
        nop("drain15",     2'd0, 2'd0);

        // flushed producer must not forward to the following consumer
        cyc("fp_add3_fl",  5'd10, 5'd11, 1'b1, 5'd3,  1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
        cyc("fp_use",      5'd3,  5'd3,  1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        nop("fp_use_ex",   2'd0, 2'd0);
        nop("drain16",     2'd0, 2'd0);
        nop("drain17",     2'd0, 2'd0);

        // mid-stream reset between edges
        cyc("rs_add3",     5'd10, 5'd11, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("rs_lw4",      5'd3,  5'd0,  1'b0, 5'd4,  1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        drive(5'd4, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        push("rs_before", 2'd1, 2'd0, 1'b1);
        #1;
        check();
        rst_i = 1'b0;
        #1;
        push("rs_async", 2'd0, 2'd0, 1'b0);
        check();
        @(posedge clk_i);
        #1;
        push("rs_held_edge", 2'd0, 2'd0, 1'b0);
        check();
        rst_i = 1'b1;
        cyc("rs_post_use", 5'd4,  5'd3,  1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        nop("rs_post_ex",  2'd0, 2'd0);

        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
